mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller at the RAM end of the instruction-fetch and load/store request handshakes. It serves word reads for the instruction fetcher and 1/2/4-byte reads and writes for the load/store buffer (LSB) over the 8-bit RAM port. Each accepted request gets exactly one single-cycle `ok` pulse.

## Interface
Parameters:
- `IO_HI`, default 2'b11: value of `addr[17:16]` that marks an I/O-mapped address.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `rdy`  in  1  global ready; low = freeze
- `if_en`  in  1  fetch request; held until `if_ok` is seen
- `if_addr`  in  32  fetch address; stable while `if_en` is high
- `if_ok`  out  1  one-cycle fetch-done pulse
- `if_ins`  out  32  fetched word, little-endian; valid with `if_ok`
- `lsb_en`  in  1  LSB request
- `lsb_wr`  in  1  1 = store, 0 = load
- `lsb_len`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- `lsb_addr`  in  32  start address
- `lsb_wdata`  in  32  store data; the low `len` bytes are used
- `lsb_ok`  out  1  one-cycle LSB-done pulse
- `lsb_rdata`  out  32  load data, zero-extended; valid with `lsb_ok`
- `mem_din`  in  8  RAM read byte
- `mem_dout`  out  8  RAM write byte
- `mem_a`  out  32  RAM byte address
- `mem_wr`  out  1  1 = write this cycle
- `io_buffer_full`  in  1  UART output buffer full

## Operation
- States: IDLE, READ, WRITE, DONE. A 3-bit byte counter `idx` and a byte count `n` are latched at request accept (IF: `n`=4; LSB: `n`=1/2/4).
- IDLE behaviour, sampled at a clock edge:
  - If `lsb_en` is high, accept the LSB request. LSB has fixed priority over IF.
  - Otherwise, if `if_en` is high, accept the IF request.
  - Accept latches the address, `n`, `wdata` and the requester ID, sets `idx`=0, and goes to READ or WRITE.
- READ:
  - In the cycle with `idx`=i, drive `mem_a`=addr+i and `mem_wr`=0.
  - Byte i arrives on `mem_din` one cycle later and is written into byte lane i of the data register.
  - After byte n-1 is captured, go to DONE.
- WRITE:
  - In the cycle with `idx`=i, drive `mem_a`=addr+i, `mem_dout`=wdata[8i+7:8i] and `mem_wr`=1.
  - After byte n-1 is issued, go to DONE.
- DONE lasts exactly one cycle:
  - Assert the requester's `ok`; data output is valid.
  - `mem_wr`=0, `mem_a`=0.
  - Both enables are ignored.
  - Next state is IDLE.
  - This cycle gives the requester one edge to drop its enable, so no request is re-accepted.
- There is no flush input. Accepted transactions always complete; on mispredict, requesters discard the stale result themselves.
- Address arithmetic is modulo 2^32.
- Data register lanes ≥ n are 0.

## Timing
- Reset: every output is 0, state is IDLE, `idx`=0.
- `rdy`=0 holds all registers and outputs; no state advances. `rst` overrides `rdy`.
- Read of n bytes, counting from the accept edge E0:
  - Address cycles are c1..cn.
  - Data is captured at the end of c2..c(n+1).
  - `ok` is high in c(n+2). IF fetch: `ok` in c6.
- Write of n bytes: write cycles are c1..cn; `ok` is high in c(n+1).
- Earliest re-accept is at the edge ending the cycle after DONE. Back-to-back word fetches therefore cost 7 cycles each.
- Simultaneous `lsb_en` and `if_en` in IDLE: LSB is served first; IF is accepted at the first IDLE after LSB's DONE.
- A requester raising its enable during a transaction or during DONE is served from the next IDLE. Its inputs must stay stable until its `ok`.

## Configuration
- `MEM_CTRL_IO_GUARD_EN` defined:
  - In WRITE, if `addr+idx` has `[17:16]`==`IO_HI` and `io_buffer_full`=1, drive `mem_wr`=0 and hold `idx`.
  - Retry every cycle until `io_buffer_full`=0; `ok` is delayed by the number of stall cycles.
  - Reads are never stalled.
- Undefined: `io_buffer_full` is ignored and writes never stall.

## Test plan
- Reset, then idle 3 cycles -> all outputs 0. `if_en`=1, `if_addr`=0x100, RAM[0x100..0x103]=13 00 00 00 -> `mem_a` = 0x100..0x103 on c1..c4; `if_ok`=1 in c6 with `if_ins`=0x00000013, high for exactly one cycle.
- `lsb_en`=1, `lsb_wr`=1, `lsb_len`=1, `lsb_addr`=0x200, `lsb_wdata`=0xAABBCCDD -> `mem_wr`=1 with (0x200, DD) in c1 and (0x201, CC) in c2; `lsb_ok` in c3; RAM[0x202] unchanged.
- `if_en` and `lsb_en` rise on the same edge, with an LSB byte load from 0x300 where RAM[0x300]=0x80 -> `lsb_ok` in c3 with `lsb_rdata`=0x00000080; IF accepted at c5's edge; `if_ok` 6 cycles later.
- Drop `rdy` for 2 cycles mid-fetch (during c3) -> `mem_a` and `idx` hold; `if_ok` is delayed by exactly 2 cycles with correct data.
- With `MEM_CTRL_IO_GUARD_EN`: byte store to 0x30000 while `io_buffer_full`=1 for 3 cycles -> `mem_wr`=0 for those 3 cycles, then one write cycle; `lsb_ok` in c5. Without the macro: `lsb_ok` in c2.
- Assert `rst` mid-write (after byte 1 of 4) -> next cycle all outputs 0 and state IDLE; a new fetch completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller shared by instruction fetch and the load/store buffer.
// Define MEM_CTRL_IO_GUARD_EN to stall I/O-mapped stores while the UART buffer is full.
module mem_ctrl #(
  parameter logic [1:0] IO_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_ok,
  output logic [31:0] if_ins,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_ok,
  output logic [31:0] lsb_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr, wdata, data;
  logic [2:0]  idx, n, lsb_n;
  logic        req_lsb;
  logic [31:0] cur_a;
  logic        io_stall;

  assign cur_a = addr + {29'd0, idx};

  always_comb begin
    case (lsb_len)
      2'd0:    lsb_n = 3'd1;
      2'd1:    lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase
  end

`ifdef MEM_CTRL_IO_GUARD_EN
  assign io_stall = (state == WRITE) && (cur_a[17:16] == IO_HI) && io_buffer_full;
`else
  logic unused_io_full;
  assign unused_io_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (lsb_en)     state_nxt = lsb_wr ? WRITE : READ;
        else if (if_en) state_nxt = READ;
      end
      // one extra cycle after the last address: RAM data lags by one cycle
      READ:  if (idx == n) state_nxt = DONE;
      WRITE: if (!io_stall && idx == n - 3'd1) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr    <= '0;
      wdata   <= '0;
      data    <= '0;
      idx     <= '0;
      n       <= '0;
      req_lsb <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          idx <= '0;
          if (lsb_en) begin
            addr    <= lsb_addr;
            wdata   <= lsb_wdata;
            n       <= lsb_n;
            req_lsb <= 1'b1;
            data    <= '0;
          end else if (if_en) begin
            addr    <= if_addr;
            wdata   <= '0;
            n       <= 3'd4;
            req_lsb <= 1'b0;
            data    <= '0;
          end
        end
        READ: begin
          if (idx != 3'd0) data[{idx - 3'd1, 3'b000} +: 8] <= mem_din;
          idx <= idx + 3'd1;
        end
        WRITE: if (!io_stall) idx <= idx + 3'd1;
        DONE:  idx <= '0;
        default: idx <= '0;
      endcase
    end
  end

  // outputs
  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if_ok    = 1'b0;
    lsb_ok   = 1'b0;
    case (state)
      READ: if (idx != n) mem_a = cur_a;
      WRITE: begin
        mem_a    = cur_a;
        mem_dout = wdata[{idx[1:0], 3'b000} +: 8];
        mem_wr   = !io_stall;
      end
      DONE: begin
        if_ok  = !req_lsb;
        lsb_ok = req_lsb;
      end
      default: ;
    endcase
  end

  assign if_ins    = data;
  assign lsb_rdata = data;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus queues expected ok pulses, a monitor checks them.
module tb_mem_ctrl;
  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic        if_en = 1'b0, lsb_en = 1'b0, lsb_wr = 1'b0, io_buffer_full = 1'b0;
  logic [1:0]  lsb_len = '0;
  logic [31:0] if_addr = '0, lsb_addr = '0, lsb_wdata = '0;
  logic [7:0]  mem_din = '0;
  logic        if_ok, lsb_ok, mem_wr;
  logic [31:0] if_ins, lsb_rdata, mem_a;
  logic [7:0]  mem_dout;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_en(if_en), .if_addr(if_addr), .if_ok(if_ok), .if_ins(if_ins),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_ok(lsb_ok), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // synchronous RAM, frozen together with the rest of the system when rdy is low
  logic [7:0] ram [0:262143];
  always @(posedge clk) begin
    if (cyc == 0) begin
      ram[18'h100] <= 8'h13; ram[18'h101] <= 8'h00; ram[18'h102] <= 8'h00; ram[18'h103] <= 8'h00;
      ram[18'h104] <= 8'h44; ram[18'h105] <= 8'h33; ram[18'h106] <= 8'h22; ram[18'h107] <= 8'h11;
      ram[18'h108] <= 8'h78; ram[18'h109] <= 8'h56; ram[18'h10a] <= 8'h34; ram[18'h10b] <= 8'h12;
      ram[18'h202] <= 8'h5A; ram[18'h300] <= 8'h80; ram[18'h402] <= 8'h00;
    end else if (rdy) begin
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end
  end

  typedef struct {
    bit          is_if;
    bit          chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every ok pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && (if_ok || lsb_ok)) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ok actual=if%0d/lsb%0d expected=none (cycle %0d)", if_ok, lsb_ok, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ok_source", {63'd0, if_ok}, {63'd0, e.is_if});
        check("ok_cycle", 64'(cyc), 64'(e.cyc));
        if (e.chk_data) check("ok_data", e.is_if ? if_ins : lsb_rdata, e.data);
      end
    end
  end

  task automatic wait_ok(input bit want_if, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (want_if ? if_ok : lsb_ok) seen = 1'b1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_ok expected=ok (cycle %0d)", name, cyc);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {if_ok, lsb_ok, mem_wr, mem_a, mem_dout}, 64'd0);
    check({name, "_data"}, {if_ins, lsb_rdata}, 64'd0);
  endtask

  initial begin
    int k;
    bit done;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");

    // word fetch
    k = cyc; if_addr = 32'h100; if_en = 1'b1;
    sb.push_back('{1'b1, 1'b1, 32'h0000_0013, k + 6});
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("fetch_addr", mem_a, 64'h100 + 64'(j));
    end
    wait_ok(1'b1, "fetch");
    if_en = 1'b0;
    @(negedge clk);
    check("if_ok_one_cycle", {63'd0, if_ok}, 64'd0);

    // half-word store
    k = cyc; lsb_en = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd1;
    lsb_addr = 32'h200; lsb_wdata = 32'hAABBCCDD;
    sb.push_back('{1'b0, 1'b0, 32'h0, k + 3});
    @(negedge clk);
    check("st_c1", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h200, 8'hDD});
    @(negedge clk);
    check("st_c2", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h201, 8'hCC});
    wait_ok(1'b0, "store_half");
    lsb_en = 1'b0; lsb_wr = 1'b0;
    @(negedge clk);
    check("st_ram", {ram[18'h200], ram[18'h201], ram[18'h202]}, 64'hDDCC5A);

    // simultaneous requests: LSB byte load first, then fetch
    k = cyc; lsb_en = 1'b1; lsb_len = 2'd0; lsb_addr = 32'h300;
    if_en = 1'b1; if_addr = 32'h104;
    sb.push_back('{1'b0, 1'b1, 32'h0000_0080, k + 3});
    sb.push_back('{1'b1, 1'b1, 32'h1122_3344, k + 10});
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (lsb_ok) lsb_en = 1'b0;
      if (if_ok) begin if_en = 1'b0; done = 1'b1; end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL priority_timeout actual=no_if_ok expected=if_ok (cycle %0d)", cyc);
      if_en = 1'b0; lsb_en = 1'b0;
    end

    // rdy freeze during fetch c3
    @(negedge clk);
    k = cyc; if_addr = 32'h108; if_en = 1'b1;
    sb.push_back('{1'b1, 1'b1, 32'h1234_5678, k + 8});
    repeat (3) @(negedge clk);
    check("frz_addr_c3", mem_a, 64'h10a);
    rdy = 1'b0;
    @(negedge clk);
    check("frz_addr_hold1", mem_a, 64'h10a);
    @(negedge clk);
    check("frz_addr_hold2", mem_a, 64'h10a);
    rdy = 1'b1;
    wait_ok(1'b1, "fetch_frozen");
    if_en = 1'b0;

    // byte store to I/O space while the UART buffer is full
    @(negedge clk);
    k = cyc; io_buffer_full = 1'b1;
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h0000_00EE;
`ifdef MEM_CTRL_IO_GUARD_EN
    sb.push_back('{1'b0, 1'b0, 32'h0, k + 5});
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("io_stall_no_wr", {63'd0, mem_wr}, 64'd0);
    end
    @(posedge clk);
    #1 io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'hEE});
`else
    sb.push_back('{1'b0, 1'b0, 32'h0, k + 2});
    @(negedge clk);
    check("io_write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h30000, 8'hEE});
`endif
    wait_ok(1'b0, "io_store");
    lsb_en = 1'b0; lsb_wr = 1'b0; io_buffer_full = 1'b0;
    @(negedge clk);
    check("io_ram", {56'd0, ram[18'h30000]}, 64'hEE);

    // reset in the middle of a word store
    k = cyc; lsb_en = 1'b1; lsb_wr = 1'b1; lsb_len = 2'd2;
    lsb_addr = 32'h400; lsb_wdata = 32'h0102_0304;
    @(negedge clk);
    check("rst_st_c1", {mem_wr, mem_a}, {1'b1, 32'h400});
    @(negedge clk);
    check("rst_st_c2", {mem_wr, mem_a}, {1'b1, 32'h401});
    rst = 1'b1; lsb_en = 1'b0; lsb_wr = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst_outputs");
    rst = 1'b0;
    @(negedge clk);
    check("rst_no_more_writes", {56'd0, ram[18'h402]}, 64'h00);
    k = cyc; if_addr = 32'h100; if_en = 1'b1;
    sb.push_back('{1'b1, 1'b1, 32'h0000_0013, k + 6});
    wait_ok(1'b1, "fetch_after_rst");
    if_en = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end
endmodule
